spi_slave_rx: RTL

//  SPI slave endpoint, downstream of the 4-select SPI master: one instance per select line.

---
 rtl/spi_slave_rx_if.sv | 27 ++
 rtl/spi_slave_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// Bus bundle between an SPI slave receiver and its surroundings: SPI pins plus the
// local tx-load and rx valid/ack handshake.
// slave modport is the receiver's view; master modport is the SPI master/host side.
interface spi_slave_rx_if #(
  parameter int DATA_W = 8
);
  logic              sclk;      // SPI clock from master, idle low (mode 0)
  logic              ss;        // slave select, active-high
  logic              mosi;      // serial data from master
  logic              miso;      // serial data to master
  logic [DATA_W-1:0] tx_data;   // byte to return on MISO
  logic              tx_load;   // 1-cycle strobe capturing tx_data
  logic [DATA_W-1:0] rx_data;   // last complete received word
  logic              rx_valid;  // rx_data holds an unacknowledged word
  logic              rx_ack;    // consumer accepts rx_data
  logic              rx_ovr;    // sticky overrun flag

  modport slave (
    input  sclk, ss, mosi, tx_data, tx_load, rx_ack,
    output miso, rx_data, rx_valid, rx_ovr
  );

  modport master (
    output sclk, ss, mosi, tx_data, tx_load, rx_ack,
    input  miso, rx_data, rx_valid, rx_ovr
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversamples sclk/ss/mosi on clk, deserialises MSB-first words, serialises tx_hold on MISO.
// Latency: rx_valid rises SYNC_STAGES+2 clk after the final sclk rising pin edge.
// Backpressure: none toward the SPI bus; unacked rx_data is overwritten (overrun) by the next word.
// Ports: clk, rst (async active-high) plain; bus (spi_slave_rx_if.slave) carries sclk/ss/mosi/miso,
//   tx_data/tx_load, rx_data/rx_valid/rx_ack and rx_ovr.
// Option: define SPI_SLAVE_OVR_EN to build the sticky rx_ovr flag; otherwise rx_ovr is tied 0.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_rx_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // ---------------- synchronisers and sclk edge detect ----------------
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall;
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // ---------------- datapath / FSM state ----------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]   tx_hold_q, tx_hold_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                miso_q, miso_d;
  // done_q: word completed on the previous cycle's rise; publishes rx_shift next cycle.
  logic                done_q, done_d;
  // reload_q: tx_shift was just reloaded at a word boundary, so the next fall must
  // present its MSB rather than shifting it away.
  logic                reload_q, reload_d;
`ifdef SPI_SLAVE_OVR_EN
  logic                rx_ovr_q, rx_ovr_d;
  logic                ovr_evt;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = bus.tx_load ? bus.tx_data : tx_hold_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    reload_d   = reload_q;

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        reload_d  = 1'b0;
        if (ss_s) state_d = LOAD;
      end
      LOAD: begin
        tx_shift_d = tx_hold_q;
        miso_d     = tx_hold_q[DATA_W-1];
        state_d    = ss_s ? SHIFT : IDLE;
      end
      SHIFT: begin
        if (!ss_s) begin
          // Deselect drops any partial word; published rx_data is left alone.
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              done_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sclk_fall) begin
            if (reload_q) begin
              miso_d   = tx_shift_q[DATA_W-1];
              reload_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
              miso_d     = tx_shift_q[DATA_W-2];
            end
          end
          // Word boundary: next word returns whatever tx_hold holds now.
          if (done_q) begin
            tx_shift_d = tx_hold_q;
            reload_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Receive handshake; a completing word beats a concurrent ack.
    if (done_q) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end else if (bus.rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

`ifdef SPI_SLAVE_OVR_EN
    ovr_evt  = done_q && rx_valid_q && !bus.rx_ack;
    rx_ovr_d = rx_ovr_q;
    if (ovr_evt)          rx_ovr_d = 1'b1;
    else if (bus.rx_ack)  rx_ovr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      reload_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      miso_q     <= miso_d;
      done_q     <= done_d;
      reload_q   <= reload_d;
    end
  end

`ifdef SPI_SLAVE_OVR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_ovr_q <= 1'b0;
    else     rx_ovr_q <= rx_ovr_d;
  end
  assign bus.rx_ovr = rx_ovr_q;
`else
  assign bus.rx_ovr = 1'b0;
`endif

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
